// File: rtl/watch_pkg.sv
// Shared encodings and default timing constants for the watch control unit.
// Watch control-unit build option: WATCH_CU_AUTOREPEAT_EN.
package watch_pkg;

  typedef logic [0:0] state_t;

  localparam state_t S_RUN  = 1'b0;
  localparam state_t S_EDIT = 1'b1;

  localparam logic [1:0] CUR_HOUR = 2'b00;
  localparam logic [1:0] CUR_MIN  = 2'b01;
  localparam logic [1:0] CUR_SEC  = 2'b10;
  localparam logic [1:0] CUR_MSEC = 2'b11;

  localparam int DEF_REPEAT_DELAY = 50;
  localparam int DEF_REPEAT_RATE  = 10;
  localparam int DEF_EDIT_TIMEOUT = 1000;
  localparam int DEF_BLINK_HALF   = 25;

endpackage

// File: rtl/watch_cu_btn_edge.sv
// Per-button rising-edge detector; the previous level resets high so that
// a button held through reset release produces no edge.
module btn_edge
  import watch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b1;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/watch_cu.sv
// Watch button control unit: RUN/EDIT FSM, cursor, command pulses, blink.
// Optional held-button auto-repeat: define WATCH_CU_AUTOREPEAT_EN.
module watch_cu
  import watch_pkg::*;
#(
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int EDIT_TIMEOUT = DEF_EDIT_TIMEOUT,
  parameter int BLINK_HALF   = DEF_BLINK_HALF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick_100hz,
  input  logic       btn_mode,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] cursor,
  output logic       inc_pulse,
  output logic       dec_pulse,
  output logic       reset_pulse,
  output logic       edit_mode,
  output logic       blink
);

  localparam int TW = $clog2(EDIT_TIMEOUT) + 1;
  localparam int BW = $clog2(BLINK_HALF) + 1;

  logic e_mode, e_left, e_right, e_up, e_down;

  btn_edge u_mode  (.clk(clk), .reset(reset), .level(btn_mode),  .rise(e_mode));
  btn_edge u_left  (.clk(clk), .reset(reset), .level(btn_left),  .rise(e_left));
  btn_edge u_right (.clk(clk), .reset(reset), .level(btn_right), .rise(e_right));
  btn_edge u_up    (.clk(clk), .reset(reset), .level(btn_up),    .rise(e_up));
  btn_edge u_down  (.clk(clk), .reset(reset), .level(btn_down),  .rise(e_down));

  state_t        state, state_nxt;
  logic [TW-1:0] tcnt;
  logic [BW-1:0] bcnt;
  logic          in_edit, act, any_edge, tout;
  logic          rep_inc, rep_dec, rep_any;
  logic          cmd_inc, cmd_dec, cmd_rst;

  assign in_edit  = (state == S_EDIT);
  // a mode edge swallows every other edge of the same cycle
  assign act      = in_edit & ~e_mode;
  assign any_edge = e_mode | e_left | e_right | e_up | e_down;
  assign rep_any  = rep_inc | rep_dec;

  assign cmd_rst = act & ((e_up & btn_down) | (e_down & btn_up));
  assign cmd_inc = act & ~cmd_rst & (e_up | rep_inc);
  assign cmd_dec = act & ~cmd_rst & ~cmd_inc & (e_down | rep_dec);

  assign tout = in_edit & i_tick_100hz & ~any_edge & ~rep_any
              & (tcnt >= TW'(EDIT_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    if (in_edit) begin
      if (e_mode || tout) state_nxt = S_RUN;
    end else if (e_mode) begin
      state_nxt = S_EDIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_RUN;
      edit_mode   <= 1'b0;
      cursor      <= CUR_HOUR;
      inc_pulse   <= 1'b0;
      dec_pulse   <= 1'b0;
      reset_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      edit_mode   <= (state_nxt == S_EDIT);
      inc_pulse   <= cmd_inc;
      dec_pulse   <= cmd_dec;
      reset_pulse <= cmd_rst;
      if (!in_edit) begin
        if (e_mode) cursor <= CUR_HOUR;
      end else if (act && (e_right ^ e_left)) begin
        cursor <= e_right ? cursor + 2'd1 : cursor - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (!in_edit || any_edge || rep_any) begin
      tcnt <= '0;
    end else if (i_tick_100hz && tcnt != TW'(EDIT_TIMEOUT)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink <= 1'b0;
      bcnt  <= '0;
    end else if (state_nxt != S_EDIT) begin
      blink <= 1'b0;
      bcnt  <= '0;
    end else if (!in_edit) begin
      blink <= 1'b1;
      bcnt  <= '0;
    end else if (i_tick_100hz) begin
      if (bcnt == BW'(BLINK_HALF - 1)) begin
        blink <= ~blink;
        bcnt  <= '0;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

`ifdef WATCH_CU_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX) + 1;

  logic [RW-1:0] rcnt, rlim;
  logic          rarm, rfirst, sole, rhit;

  // only a single held up/down key repeats; pressing both stops it
  assign sole = btn_up ^ btn_down;
  assign rlim = rfirst ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_RATE - 1);
  assign rhit = rarm & sole & act & i_tick_100hz
              & ~e_up & ~e_down & (rcnt == rlim);
  assign rep_inc = rhit & btn_up;
  assign rep_dec = rhit & btn_down;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt   <= '0;
      rarm   <= 1'b0;
      rfirst <= 1'b0;
    end else if (!act || !sole) begin
      rcnt <= '0;
      rarm <= 1'b0;
    end else if (e_up || e_down) begin
      rcnt   <= '0;
      rarm   <= 1'b1;
      rfirst <= 1'b1;
    end else if (rarm && i_tick_100hz) begin
      if (rhit) begin
        rcnt   <= '0;
        rfirst <= 1'b0;
      end else begin
        rcnt <= rcnt + 1'b1;
      end
    end
  end
`else
  assign rep_inc = 1'b0;
  assign rep_dec = 1'b0;
`endif

endmodule

// File: tb/tb_watch_cu.sv
// Directed bench for watch_cu with a pulse scoreboard.
// Build with WATCH_CU_AUTOREPEAT_EN to cover auto-repeat.
module tb_watch_cu;

  localparam int K_INC = 1;
  localparam int K_DEC = 2;
  localparam int K_RST = 3;

  localparam int B_MODE  = 0;
  localparam int B_LEFT  = 1;
  localparam int B_RIGHT = 2;
  localparam int B_UP    = 3;
  localparam int B_DOWN  = 4;

  logic       clk;
  logic       reset;
  logic       i_tick_100hz;
  logic       btn_mode, btn_left, btn_right, btn_up, btn_down;
  logic [1:0] cursor;
  logic       inc_pulse, dec_pulse, reset_pulse;
  logic       edit_mode, blink;

  int checks = 0;
  int errors = 0;
  int expq[$];

  watch_cu dut (
    .clk(clk),
    .reset(reset),
    .i_tick_100hz(i_tick_100hz),
    .btn_mode(btn_mode),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .cursor(cursor),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .reset_pulse(reset_pulse),
    .edit_mode(edit_mode),
    .blink(blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic setb(input int b, input logic v);
    case (b)
      B_MODE:  btn_mode  = v;
      B_LEFT:  btn_left  = v;
      B_RIGHT: btn_right = v;
      B_UP:    btn_up    = v;
      default: btn_down  = v;
    endcase
  endtask

  task automatic tap(input int b);
    setb(b, 1'b1);
    cyc(1);
    setb(b, 1'b0);
    cyc(1);
  endtask

  task automatic tick_one();
    i_tick_100hz = 1'b1;
    cyc(1);
    i_tick_100hz = 1'b0;
    cyc(1);
  endtask

  // every observed pulse must be the next expected one, and only one at a time
  always @(negedge clk) begin
    int kind;
    if (!reset && (inc_pulse || dec_pulse || reset_pulse)) begin
      kind = inc_pulse ? K_INC : (dec_pulse ? K_DEC : K_RST);
      check("pulse_onehot", 32'(inc_pulse) + 32'(dec_pulse) + 32'(reset_pulse), 1);
      if (expq.size() == 0) check("unexpected_pulse", kind, 0);
      else check("pulse_kind", kind, expq.pop_front());
    end
  end

  initial begin
    int rexp[5] = '{1, 2, 3, 0, 1};
    reset = 1'b1;
    i_tick_100hz = 1'b0;
    btn_mode = 0; btn_left = 0; btn_right = 0; btn_up = 1; btn_down = 0;
    cyc(3);
    check("rst_edit", edit_mode, 0);
    check("rst_cursor", cursor, 0);
    check("rst_blink", blink, 0);
    check("rst_pulses", {inc_pulse, dec_pulse, reset_pulse}, 0);

    reset = 1'b0;
    cyc(3);
    setb(B_UP, 1'b0);
    cyc(1);
    tap(B_UP);
    tap(B_RIGHT);
    check("run_cursor", cursor, 0);
    check("run_edit", edit_mode, 0);

    setb(B_MODE, 1'b1);
    cyc(1);
    check("enter_edit", edit_mode, 1);
    check("enter_cursor", cursor, 0);
    check("enter_blink", blink, 1);
    setb(B_MODE, 1'b0);
    cyc(1);

    for (int i = 0; i < 5; i++) begin
      tap(B_RIGHT);
      check("cur_right", cursor, rexp[i]);
    end
    tap(B_LEFT);
    check("cur_left", cursor, 0);
    tap(B_LEFT);
    check("cur_left_wrap", cursor, 3);
    tap(B_RIGHT);
    check("cur_right_wrap", cursor, 0);
    tap(B_RIGHT);
    btn_left = 1; btn_right = 1;
    cyc(1);
    btn_left = 0; btn_right = 0;
    cyc(1);
    check("cur_both", cursor, 1);

    for (int i = 0; i < 3; i++) begin
      expq.push_back(K_INC);
      tap(B_UP);
    end
    expq.push_back(K_INC);
    setb(B_UP, 1'b1);
    cyc(2);
    expq.push_back(K_RST);
    setb(B_DOWN, 1'b1);
    cyc(1);
    setb(B_DOWN, 1'b0);
    cyc(1);
    setb(B_UP, 1'b0);
    cyc(1);
    expq.push_back(K_RST);
    btn_up = 1; btn_down = 1;
    cyc(1);
    btn_up = 0; btn_down = 0;
    cyc(1);
    expq.push_back(K_DEC);
    tap(B_DOWN);
    cyc(1);
    check("q_drain_taps", expq.size(), 0);

    btn_mode = 1; btn_up = 1; btn_right = 1;
    cyc(1);
    check("mode_prio_edit", edit_mode, 0);
    check("mode_prio_cursor", cursor, 1);
    btn_mode = 0; btn_up = 0; btn_right = 0;
    cyc(1);

    tap(B_MODE);
    check("reenter_edit", edit_mode, 1);
    check("reenter_cursor", cursor, 0);
    repeat (24) tick_one();
    check("blink_t24", blink, 1);
    tick_one();
    check("blink_t25", blink, 0);
    repeat (25) tick_one();
    check("blink_t50", blink, 1);
    tap(B_MODE);
    check("exit_edit", edit_mode, 0);
    check("exit_blink", blink, 0);

    tap(B_MODE);
    repeat (999) tick_one();
    tap(B_RIGHT);
    check("to_restart_edit", edit_mode, 1);
    check("to_restart_cursor", cursor, 1);
    repeat (999) tick_one();
    check("to_t999", edit_mode, 1);
    i_tick_100hz = 1'b1;
    cyc(1);
    check("to_t1000", edit_mode, 0);
    i_tick_100hz = 1'b0;
    cyc(1);
    check("to_blink", blink, 0);

    tap(B_MODE);
    expq.push_back(K_DEC);
    setb(B_DOWN, 1'b1);
    cyc(1);
    for (int t = 1; t <= 80; t++) begin
`ifdef WATCH_CU_AUTOREPEAT_EN
      if (t >= 50 && (t - 50) % 10 == 0) expq.push_back(K_DEC);
`endif
      tick_one();
    end
    check("rep_drain", expq.size(), 0);
    setb(B_DOWN, 1'b0);
    cyc(1);
    repeat (20) tick_one();
    check("rep_release_edit", edit_mode, 1);

    expq.push_back(K_INC);
    setb(B_UP, 1'b1);
    cyc(1);
    for (int t = 1; t <= 55; t++) begin
`ifdef WATCH_CU_AUTOREPEAT_EN
      if (t == 50) expq.push_back(K_INC);
`endif
      tick_one();
    end
    reset = 1'b1;
    cyc(2);
    check("midrep_rst_edit", edit_mode, 0);
    check("midrep_rst_cursor", cursor, 0);
    check("midrep_rst_blink", blink, 0);
    reset = 1'b0;
    cyc(1);
    repeat (20) tick_one();
    check("post_rst_edit", edit_mode, 0);
    setb(B_UP, 1'b0);
    cyc(3);
    check("q_final", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_cu.md
WATCH_CU -- requirements
Module: watch_cu

Interface
REQ-001 Parameter REPEAT_DELAY, default 50: 100 Hz ticks of continuous hold before the first auto-repeat pulse (500 ms).
REQ-002 Parameter REPEAT_RATE, default 10: 100 Hz ticks between subsequent auto-repeat pulses (100 ms).
REQ-003 Parameter EDIT_TIMEOUT, default 1000: 100 Hz ticks without a button edge before EDIT exits (10 s).
REQ-004 Parameter BLINK_HALF, default 25: 100 Hz ticks per blink half-period.
REQ-005 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 i_tick_100hz  input  1  one-clk-wide 10 ms time-base strobe.
REQ-008 btn_mode, btn_left, btn_right, btn_up, btn_down  input  1 each  debounced, clk-synchronous, active-high button levels.
REQ-009 cursor  output  2  selected field: 00 hour, 01 min, 10 sec, 11 msec.
REQ-010 inc_pulse, dec_pulse, reset_pulse  output  1 each  registered one-clk command pulses to the watch datapath.
REQ-011 edit_mode  output  1  high while the FSM is in EDIT.
REQ-012 blink  output  1  field-blink enable for the display.

Function
REQ-013 Rising edge per button SHALL be detected as level=1 with previous-cycle level=0; an edge sampled at cycle N SHALL produce its output effect in cycle N+1.
REQ-014 FSM states: RUN and EDIT. RUN->EDIT on a btn_mode edge, with cursor loaded to 00. EDIT->RUN on a btn_mode edge or on timeout.
REQ-015 In RUN, left/right/up/down edges SHALL be ignored, and cursor SHALL hold its value.
REQ-016 In EDIT, a right edge SHALL set cursor to cursor+1 (11 wraps to 00); a left edge SHALL set cursor to cursor-1 (00 wraps to 11).
REQ-017 Simultaneous left and right edges SHALL leave cursor unchanged.
REQ-018 In EDIT, an up edge SHALL produce inc_pulse for exactly one clk, and a down edge SHALL produce dec_pulse for exactly one clk.
REQ-019 In EDIT, an up edge while down is high, or a down edge while up is high, including both edges in the same cycle, SHALL produce reset_pulse for one clk and no inc_pulse or dec_pulse.
REQ-020 A btn_mode edge SHALL take priority: all other edges in that cycle are ignored.
REQ-021 At most one of inc_pulse, dec_pulse, reset_pulse SHALL be high in any cycle.
REQ-022 The timeout counter SHALL clear on EDIT entry and on any button edge, and increment on i_tick_100hz in EDIT.
REQ-023 When the timeout counter reaches EDIT_TIMEOUT, the FSM SHALL enter RUN, and the counter SHALL saturate and not wrap.
REQ-024 edit_mode SHALL equal (state==EDIT) and be driven from a register.
REQ-025 blink SHALL be 0 in RUN and 1 in the first cycle of EDIT.
REQ-026 In EDIT, blink SHALL toggle after every BLINK_HALF i_tick_100hz strobes.
REQ-027 Counter widths SHALL be derived with $clog2 of the corresponding parameter plus 1.

Reset
REQ-028 On reset, the FSM SHALL enter RUN, cursor SHALL be 00, and all pulses, edit_mode and blink SHALL be 0.
REQ-029 On reset, all counters SHALL be 0, and every previous-level register SHALL be 1, so that a button held through reset release creates no edge.
REQ-030 Reset asserted mid-EDIT or mid-repeat SHALL abort the operation immediately, with no pulse emitted afterward.

Configuration
REQ-031 With WATCH_CU_AUTOREPEAT_EN defined, a sole up or down button held in EDIT SHALL emit an extra pulse of its kind on the REPEAT_DELAY-th tick after its edge, then every REPEAT_RATE ticks.
REQ-032 With WATCH_CU_AUTOREPEAT_EN defined, repeat pulses SHALL count as activity for the timeout, and releasing the button or pressing both buttons SHALL stop repetition.
REQ-033 Without WATCH_CU_AUTOREPEAT_EN, exactly one pulse SHALL be emitted per press, and the repeat counters SHALL not be instantiated.

Structure
REQ-034 Shared package watch_pkg SHALL hold the cursor encodings (CUR_HOUR, CUR_MIN, CUR_SEC, CUR_MSEC), the FSM state typedef, and the default parameter constants.
REQ-035 One sub-module, btn_edge, SHALL handle per-button previous-level storage and rising-edge output, and be instantiated five times.

Verification
REQ-036 Reset, then a btn_mode edge -> edit_mode=1 and cursor=00 one clk later; blink=1.
REQ-037 EDIT, right pressed 5 times -> cursor 01,10,11,00,01; then left once -> 00.
REQ-038 EDIT with cursor=01, up tapped 3 times -> exactly 3 single-clk inc_pulse; up held, then down pressed -> one reset_pulse and no dec_pulse.
REQ-039 EDIT, idle for 1000 ticks -> edit_mode=0 on the tick-1000 cycle+1; a right edge at tick 999 restarts the count.
REQ-040 WATCH_CU_AUTOREPEAT_EN defined, down held for 80 ticks -> dec_pulse at the edge, tick 50, tick 60, tick 70, tick 80 (5 total).
REQ-041 btn_up held across reset release -> no inc_pulse; RUN state, up edge -> no pulse.
